// File: rtl/mmio_pkg.sv
// mmio_pkg: IO page offsets and STATUS bit indices shared by the MMIO responder
package mmio_pkg;
  localparam logic [7:0] OFF_OPR1   = 8'h00;
  localparam logic [7:0] OFF_OPR2   = 8'h04;
  localparam logic [7:0] OFF_RESULT = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam int ST_OPR1 = 0;
  localparam int ST_OPR2 = 1;
endpackage

// File: rtl/mmio_debounce.sv
// mmio_debounce: 2-flop sync, stability counter and debounced register with change pulse
module mmio_debounce #(
  parameter int W   = 8,
  parameter int CYC = 1000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] raw,
  output logic [W-1:0] q,
  output logic         changed
);
  localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYC - 1);
  logic [W-1:0] s1, s2, cand;
  logic [CW-1:0] cnt;
  assign changed = (s2 == cand) && (cnt == LAST) && (cand != q);
  // synchronise, restart the count on any change, commit once stable long enough
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= '0;
      s2 <= '0;
      cand <= '0;
      cnt <= '0;
      q <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt <= '0;
      end else if (cnt < LAST) cnt <= cnt + 1'b1;
      if (changed) q <= cand;
    end
  end
endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: DMEM bus responder serving word RAM and an IO page (optional CYCLE counter via MMIO_CYCLE_COUNTER_EN)
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int          RAM_AW       = 10,
  parameter logic [23:0] IO_PAGE      = 24'h0000FF,
  parameter logic [15:0] DEBOUNCE_CYC = 16'd1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  opr1,
  input  logic [7:0]  opr2,
  output logic [15:0] result
);
  logic io_sel, io_we, chg1, chg2;
  logic [7:0] off, opr1_db, opr2_db;
  logic [RAM_AW-1:0] widx;
  logic [31:0] mem [2**RAM_AW];
  logic [31:0] cycle_rd;
  logic [1:0] status, st_set, st_clr;
  assign io_sel = addr[31:8] == IO_PAGE;
  assign io_we  = we && io_sel;
  assign off    = addr[7:0] & 8'hFC;
  assign widx   = addr[RAM_AW+1:2];
  mmio_debounce #(.W(8), .CYC(int'(DEBOUNCE_CYC))) u_db1 (
    .clk(clk), .resetn(resetn), .raw(opr1), .q(opr1_db), .changed(chg1)
  );
  mmio_debounce #(.W(8), .CYC(int'(DEBOUNCE_CYC))) u_db2 (
    .clk(clk), .resetn(resetn), .raw(opr2), .q(opr2_db), .changed(chg2)
  );
  // word RAM, contents deliberately not reset
  always_ff @(posedge clk) begin
    if (we && !io_sel) mem[widx] <= wdata;
  end
  // RESULT register keeps the low half of stores
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) result <= '0;
    else if (io_we && off == OFF_RESULT) result <= wdata[15:0];
  end
  // sticky change flags: new change wins over a simultaneous write-1-to-clear
  always_comb begin
    st_set = '0;
    st_set[ST_OPR1] = chg1;
    st_set[ST_OPR2] = chg2;
    st_clr = (io_we && off == OFF_STATUS) ? wdata[1:0] : 2'b00;
  end
  // STATUS register update
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) status <= '0;
    else status <= (status & ~st_clr) | st_set;
  end
`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0] cycle;
  // free-running cycle counter, wraps naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cycle <= '0;
    else cycle <= cycle + 32'd1;
  end
  assign cycle_rd = cycle;
`else
  assign cycle_rd = '0;
`endif
  // same-cycle load data mux
  always_comb begin
    rdata = !io_sel              ? mem[widx] :
            off == OFF_OPR1      ? {24'b0, opr1_db} :
            off == OFF_OPR2      ? {24'b0, opr2_db} :
            off == OFF_RESULT    ? {16'b0, result} :
            off == OFF_STATUS    ? {30'b0, status} :
            off == OFF_CYCLE     ? cycle_rd : 32'b0;
  end
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed table plus multi-cycle sequences for the MMIO responder
module tb_mmio_responder;
  logic clk = 0, resetn, we;
  logic [31:0] addr, wdata, rdata;
  logic [7:0] opr1, opr2;
  logic [15:0] result;
  int total = 0, bad = 0;
  logic [31:0] d, c0, c1;

  mmio_responder #(.RAM_AW(10), .IO_PAGE(24'h0000FF), .DEBOUNCE_CYC(16'd4)) dut (
    .clk(clk), .resetn(resetn), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .opr1(opr1), .opr2(opr2), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic [15:0] res;
  } vec_t;
  vec_t v[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    we = 0;
    addr = a;
    #1;
    q = rdata;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] dat);
    we = 1;
    addr = a;
    wdata = dat;
    tick();
    we = 0;
  endtask

  initial begin
    v[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 16'h0};
    v[1]  = '{1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 16'h0};
    v[2]  = '{1'b0, 32'h0000_1040, 32'h0, 32'hDEAD_BEEF, 16'h0};
    v[3]  = '{1'b1, 32'h0000_0044, 32'h1234_5678, 32'h0, 16'h0};
    v[4]  = '{1'b0, 32'h0000_0047, 32'h0, 32'h1234_5678, 16'h0};
    v[5]  = '{1'b1, 32'h0000_FF08, 32'h1234_ABCD, 32'h0, 16'hABCD};
    v[6]  = '{1'b0, 32'h0000_FF08, 32'h0, 32'h0000_ABCD, 16'hABCD};
    v[7]  = '{1'b1, 32'h0000_FF20, 32'hFFFF_FFFF, 32'h0, 16'hABCD};
    v[8]  = '{1'b0, 32'h0000_FF20, 32'h0, 32'h0, 16'hABCD};
    v[9]  = '{1'b1, 32'h0000_FF00, 32'hCAFE_BABE, 32'h0, 16'hABCD};
    v[10] = '{1'b0, 32'h0000_FF00, 32'h0, 32'h0, 16'hABCD};
    v[11] = '{1'b0, 32'h0000_FF0C, 32'h0, 32'h0, 16'hABCD};
    v[12] = '{1'b0, 32'h0000_FF09, 32'h0, 32'h0000_ABCD, 16'hABCD};
    resetn = 0; we = 0; addr = 0; wdata = 0; opr1 = 0; opr2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1;
    tick();
    chk("reset_result", {16'b0, result}, 32'h0);
    rd(32'hFF00, d); chk("reset_opr1", d, 32'h0);
    rd(32'hFF0C, d); chk("reset_status", d, 32'h0);
    for (int i = 0; i < 13; i++) begin
      we = v[i].we; addr = v[i].addr; wdata = v[i].wdata;
      #1;
      if (!v[i].we) chk($sformatf("vec%0d_rdata", i), rdata, v[i].exp);
      tick();
      we = 0;
      chk($sformatf("vec%0d_result", i), {16'b0, result}, {16'b0, v[i].res});
    end
    opr1 = 8'h5A;
    tick();
    repeat (5) tick();
    rd(32'hFF00, d); chk("db_early", d, 32'h0);
    tick();
    rd(32'hFF00, d); chk("db_opr1", d, 32'h5A);
    rd(32'hFF0C, d); chk("db_status", d, 32'h1);
    st(32'hFF0C, 32'h1);
    rd(32'hFF0C, d); chk("w1c_clear1", d, 32'h0);
    opr1 = 8'hFF; tick(); tick(); opr1 = 8'h5A;
    repeat (10) tick();
    rd(32'hFF00, d); chk("glitch_opr1", d, 32'h5A);
    rd(32'hFF0C, d); chk("glitch_status", d, 32'h0);
    opr2 = 8'h33;
    repeat (7) tick();
    rd(32'hFF0C, d); chk("opr2_status", d, 32'h2);
    rd(32'hFF04, d); chk("opr2_val", d, 32'h33);
    opr1 = 8'h11;
    repeat (7) tick();
    rd(32'hFF0C, d); chk("both_status", d, 32'h3);
    rd(32'hFF00, d); chk("opr1_11", d, 32'h11);
    st(32'hFF0C, 32'h1);
    rd(32'hFF0C, d); chk("w1c_bit0", d, 32'h2);
    st(32'hFF0C, 32'h2);
    rd(32'hFF0C, d); chk("w1c_bit1", d, 32'h0);
    opr2 = 8'h44;
    repeat (6) tick();
    rd(32'hFF04, d); chk("setwin_pre", d, 32'h33);
    st(32'hFF0C, 32'h2);
    rd(32'hFF0C, d); chk("setwin_status", d, 32'h2);
    rd(32'hFF04, d); chk("setwin_opr2", d, 32'h44);
    opr1 = 8'h77;
    tick();
    repeat (4) tick();
    #2 resetn = 0;
    #1;
    chk("arst_result", {16'b0, result}, 32'h0);
    rd(32'hFF00, d); chk("arst_opr1", d, 32'h0);
    rd(32'hFF0C, d); chk("arst_status", d, 32'h0);
    @(negedge clk) resetn = 1;
    tick();
    repeat (6) tick();
    rd(32'hFF00, d); chk("post_opr1", d, 32'h77);
    rd(32'hFF04, d); chk("post_opr2", d, 32'h44);
    rd(32'hFF0C, d); chk("post_status", d, 32'h3);
    rd(32'hFF10, c0);
    repeat (7) tick();
    rd(32'hFF10, c1);
`ifdef MMIO_CYCLE_COUNTER_EN
    chk("cycle_delta", c1 - c0, 32'd7);
`else
    chk("cycle_off0", c0, 32'h0);
    chk("cycle_off1", c1, 32'h0);
`endif
    rd(32'hFF20, d); chk("unmapped", d, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
